// File: rtl/alu_seq.sv
// alu_seq: multi-cycle, handshaked ALU with a full flag set.
//
// Accepts one operation at a time over a valid/ready input handshake. The
// operation is iterated in BUSY: shifts move one bit per step and MUL does
// one shift-add per step. The result and flags are then held in DONE until
// the consumer accepts them over the output handshake.
//
// Ports:
//   CLK        clock; all state changes on the rising edge
//   RST_N      asynchronous active-low reset
//   IN_VALID   operation request valid
//   IN_READY   high in IDLE; the block can accept an operation
//   SEL        opcode: AND OR XOR ADD SUB SHL SHR MUL (000..111)
//   A, B       operands; for shifts the amount is B[SW-1:0]
//   OUT_VALID  result valid (DONE state)
//   OUT_READY  consumer accepts the result
//   O          2*WIDTH result; the upper half is nonzero only for MUL
//   CARRY      carry / borrow / last shift-out / high half of product nonzero
//   ZERO       O == 0
//   NEG        sign bit of the result (O[2*WIDTH-1] for MUL)
//   OVF        signed overflow for ADD/SUB
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [2:0]         SEL,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [2*WIDTH-1:0] O,
  output logic               CARRY,
  output logic               ZERO,
  output logic               NEG,
  output logic               OVF
);

  localparam int SW = $clog2(WIDTH);
  // The counter must be able to hold WIDTH itself for MUL.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;       // multiplier for MUL, shifted right each step
  logic [2*WIDTH-1:0]   work_q, work_d; // shift value, or multiplicand for MUL
  logic [2*WIDTH-1:0]   acc_q, acc_d;   // product accumulator
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 shc_q, shc_d;   // last bit shifted out
  logic [2*WIDTH-1:0]   o_q, o_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 neg_q, neg_d;
  logic                 ovf_q, ovf_d;

  // Result of the finalise step, computed from the operand/working registers.
  logic [WIDTH:0]       sum_w, diff_w;
  logic [2*WIDTH-1:0]   res_o;
  logic                 res_c, res_v;

  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  // The extra top bit of the difference is the borrow.
  assign diff_w = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    res_o = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (sel_q)
      OP_AND: res_o = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:  res_o = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR: res_o = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_ADD: begin
        res_o = {{WIDTH{1'b0}}, sum_w[WIDTH-1:0]};
        res_c = sum_w[WIDTH];
        res_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_o = {{WIDTH{1'b0}}, diff_w[WIDTH-1:0]};
        res_c = diff_w[WIDTH];
        res_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SHL, OP_SHR: begin
        res_o = {{WIDTH{1'b0}}, work_q[WIDTH-1:0]};
        res_c = shc_q;
      end
      default: begin // OP_MUL
        res_o = acc_q;
        res_c = |acc_q[2*WIDTH-1:WIDTH];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    shc_d   = shc_q;
    o_d     = o_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          sel_d  = SEL;
          a_d    = A;
          b_d    = B;
          work_d = {{WIDTH{1'b0}}, A};
          acc_d  = '0;
          shc_d  = 1'b0;
          case (SEL)
            OP_SHL, OP_SHR: cnt_d = CW'(B[SW-1:0]);
            OP_MUL:         cnt_d = CW'(WIDTH);
            default:        cnt_d = '0;
          endcase
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          o_d     = res_o;
          carry_d = res_c;
          zero_d  = (res_o == '0);
          neg_d   = (sel_q == OP_MUL) ? res_o[2*WIDTH-1] : res_o[WIDTH-1];
          ovf_d   = res_v;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          case (sel_q)
            OP_SHL: begin
              shc_d  = work_q[WIDTH-1];
              work_d = {{WIDTH{1'b0}}, work_q[WIDTH-2:0], 1'b0};
            end
            OP_SHR: begin
              shc_d  = work_q[0];
              work_d = {{WIDTH{1'b0}}, 1'b0, work_q[WIDTH-1:1]};
            end
            OP_MUL: begin
              if (b_q[0]) begin
                acc_d = acc_q + work_q;
              end
              work_d = work_q << 1;
              b_d    = b_q >> 1;
            end
            default: ;
          endcase
        end
      end
      S_DONE: begin
        if (OUT_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      shc_q   <= 1'b0;
      o_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shc_q   <= shc_d;
      o_q     <= o_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign O         = o_q;
  assign CARRY     = carry_q;
  assign ZERO      = zero_q;
  assign NEG       = neg_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): the driver pushes hand-computed
// expectations at acceptance, and a monitor pops and compares each result
// the first cycle OUT_VALID is seen, including latency from the accepting edge.
module tb_alu_seq;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [2:0]  SEL = 3'b000;
  logic [7:0]  A = 8'h00;
  logic [7:0]  B = 8'h00;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [15:0] O;
  logic        CARRY, ZERO, NEG, OVF;

  alu_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .SEL(SEL), .A(A), .B(B),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .O(O), .CARRY(CARRY), .ZERO(ZERO), .NEG(NEG), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] o;
    logic        c, z, n, v;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare once per presented result.
  bit presented = 1'b0;
  always @(negedge CLK) begin
    if (!RST_N || !OUT_VALID) begin
      presented = 1'b0;
    end else if (!presented) begin
      presented = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("result O=%04h C=%0b Z=%0b N=%0b V=%0b lat=%0d (exp O=%04h lat=%0d)",
                 O, CARRY, ZERO, NEG, OVF, cyc - e.acc_cyc, e.o, e.lat);
        chk("O", {16'h0, O}, {16'h0, e.o});
        chk("CARRY", {31'h0, CARRY}, {31'h0, e.c});
        chk("ZERO", {31'h0, ZERO}, {31'h0, e.z});
        chk("NEG", {31'h0, NEG}, {31'h0, e.n});
        chk("OVF", {31'h0, OVF}, {31'h0, e.v});
        chk("latency", cyc - e.acc_cyc, e.lat);
      end
    end
  end

  // Issue one operation; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] eo, input logic c, input logic z,
                       input logic n, input logic v, input int lat, input bit push);
    int t;
    exp_t e;
    @(negedge CLK);
    SEL = sel; A = a; B = b; IN_VALID = 1'b1;
    t = 0;
    while (!IN_READY && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (!IN_READY) begin
      chk("accept_timeout", 32'd1, 32'd0);
      IN_VALID = 1'b0;
      return;
    end
    if (push) begin
      e.o = eo; e.c = c; e.z = z; e.n = n; e.v = v; e.lat = lat; e.acc_cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge CLK);
    // Scramble inputs to confirm operands were captured at acceptance.
    IN_VALID = 1'b0; SEL = ~sel; A = ~a; B = ~b;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || !IN_READY) && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 200) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", {31'h0, IN_READY}, 32'd1);
    chk("rst_out_valid", {31'h0, OUT_VALID}, 32'd0);
    chk("rst_O", {16'h0, O}, 32'd0);
    chk("rst_flags", {28'h0, CARRY, ZERO, NEG, OVF}, 32'd0);
    RST_N = 1'b1;

    //     sel     a      b      O        C     Z     N     V    lat
    issue(3'b011, 8'hF0, 8'h20, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1); drain();
    issue(3'b100, 8'h05, 8'h07, 16'h00FE, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1); drain();
    issue(3'b100, 8'h80, 8'h01, 16'h007F, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1); drain();
    issue(3'b100, 8'h33, 8'h33, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1); drain();
    issue(3'b000, 8'hCC, 8'hAA, 16'h0088, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1); drain();
    issue(3'b001, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1); drain();
    issue(3'b011, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1); drain();
    issue(3'b101, 8'h81, 8'h03, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1); drain();
    issue(3'b110, 8'h81, 8'h01, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1); drain();
    issue(3'b101, 8'h5A, 8'h08, 16'h005A, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1); drain();
    issue(3'b110, 8'h80, 8'h07, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b1); drain();
    issue(3'b101, 8'hFF, 8'h07, 16'h0080, 1'b1, 1'b0, 1'b1, 1'b0, 8, 1'b1); drain();
    issue(3'b111, 8'h10, 8'h10, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 9, 1'b1); drain();
    issue(3'b111, 8'h03, 8'h05, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 9, 1'b1); drain();

    // MUL 0xFF*0xFF: IN_READY must stay low while busy.
    issue(3'b111, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0, 1'b1, 1'b0, 9, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy_in_ready", {31'h0, IN_READY}, 32'd0);
      @(negedge CLK);
    end
    drain();

    // Backpressure on XOR with a second request pulsed meanwhile.
    OUT_READY = 1'b0;
    issue(3'b010, 8'h0F, 8'hFF, 16'h00F0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      chk("bp_O", {16'h0, O}, 32'h00F0);
      chk("bp_out_valid", {31'h0, OUT_VALID}, 32'd1);
      chk("bp_in_ready", {31'h0, IN_READY}, 32'd0);
      if (i == 1) begin
        SEL = 3'b011; A = 8'h01; B = 8'h01; IN_VALID = 1'b1;
      end
      if (i == 3) IN_VALID = 1'b0;
      @(negedge CLK);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("bp_release_out_valid", {31'h0, OUT_VALID}, 32'd0);
    chk("bp_release_in_ready", {31'h0, IN_READY}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_second_not_taken", {31'h0, OUT_VALID}, 32'd0);
    end
    drain();

    // Reset in the middle of a MUL: abandoned, no result.
    issue(3'b111, 8'hFF, 8'hFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (4) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_out_valid", {31'h0, OUT_VALID}, 32'd0);
    chk("midrst_O", {16'h0, O}, 32'd0);
    chk("midrst_in_ready", {31'h0, IN_READY}, 32'd1);
    chk("midrst_flags", {28'h0, CARRY, ZERO, NEG, OVF}, 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    issue(3'b011, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    drain();
    repeat (3) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
